// File: rtl/riscy_pkg.sv
// Shared types and constants for the RV32IM core pipeline stages.
// No logic; latency and backpressure are defined by the stages that use it.
// Holds the decoded-op record handed from decode to the execute ALU.
package riscy_pkg;

    localparam int XLEN = 32;

    localparam logic [6:0] OPC_OP     = 7'h33;
    localparam logic [6:0] OPC_OP_IMM = 7'h13;

    localparam logic [6:0] F7_BASE    = 7'h00;
    localparam logic [6:0] F7_ALT     = 7'h20;
    localparam logic [6:0] F7_MULDIV  = 7'h01;

    typedef struct packed {
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic [XLEN-1:0] rs1;
        logic [XLEN-1:0] rs2;
        logic [4:0]      rd;
        logic            illegal;
    } dec_op_t;

    // Sign-extend a 12-bit I-type immediate to the operand width.
    function automatic logic [XLEN-1:0] sext12(input logic [11:0] imm);
        return {{(XLEN-12){imm[11]}}, imm};
    endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// Architectural register file: two combinational read ports, one write port.
// Latency: reads same cycle, writes visible the cycle after the write edge.
// Backpressure: none; writes to x0 are dropped and x0 always reads zero.
//
// Ports: clk, rst_n (async active-low, clears every register),
//        ra_addr/ra_data, rb_addr/rb_data (read), we/waddr/wdata (write).
module regfile_2r1w #(
    parameter  int XLEN  = 32,
    parameter  int NREGS = 32,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [AW-1:0]   ra_addr,
    output logic [XLEN-1:0] ra_data,
    input  logic [AW-1:0]   rb_addr,
    output logic [XLEN-1:0] rb_data,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [XLEN-1:0] wdata
);
    import riscy_pkg::*;

    logic [XLEN-1:0] mem [NREGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                mem[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            mem[waddr] <= wdata;
        end
    end

    assign ra_data = (ra_addr == '0) ? '0 : mem[ra_addr];
    assign rb_data = (rb_addr == '0) ? '0 : mem[rb_addr];

endmodule

// File: rtl/decode_stage.sv
// Decode stage: OP / OP-IMM decode, operand fetch and busy scoreboard for the ALU.
// Latency: 1 cycle from accept to out_valid (registered output).
// Backpressure: holds out_* while out_valid && !out_ready; stalls on RAW/WAW hazards.
//
// Ports: clk, rst_n (async active-low), flush (kills output register),
//        in_valid/in_ready/in_instr (instruction in),
//        out_valid/out_ready/out_funct3/out_funct7/out_rs1/out_rs2/out_rd/out_illegal (to ALU),
//        wb_en/wb_addr/wb_data (writeback; clears busy and writes the register file).
// Build option: DECODE_STAGE_BYPASS_EN forwards same-cycle writeback data into the
// operands and lets a source being written back this cycle issue without a stall.
module decode_stage #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [2:0]      out_funct3,
    output logic [6:0]      out_funct7,
    output logic [XLEN-1:0] out_rs1,
    output logic [XLEN-1:0] out_rs2,
    output logic [4:0]      out_rd,
    output logic            out_illegal,
    input  logic            wb_en,
    input  logic [4:0]      wb_addr,
    input  logic [XLEN-1:0] wb_data
);
    import riscy_pkg::*;

    // Instruction fields
    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7_raw;
    logic [4:0] rs1_idx;
    logic [4:0] rs2_idx;
    logic [4:0] rd_idx;

    assign opcode  = in_instr[6:0];
    assign rd_idx  = in_instr[11:7];
    assign f3      = in_instr[14:12];
    assign rs1_idx = in_instr[19:15];
    assign rs2_idx = in_instr[24:20];
    assign f7_raw  = in_instr[31:25];

    logic is_op;
    logic is_opimm;
    logic is_shift;

    assign is_op    = (opcode == OPC_OP);
    assign is_opimm = (opcode == OPC_OP_IMM);
    assign is_shift = is_opimm && ((f3 == 3'd1) || (f3 == 3'd5));

    // Register file and operand selection
    logic [XLEN-1:0] rf_a;
    logic [XLEN-1:0] rf_b;
    logic [XLEN-1:0] opnd_a;
    logic [XLEN-1:0] opnd_b;
    logic            wb_live;
    logic            byp_a;
    logic            byp_b;

    // x0 writebacks are architecturally meaningless: never clear, write or forward.
    assign wb_live = wb_en && (wb_addr != 5'd0);

    regfile_2r1w #(
        .XLEN  (XLEN),
        .NREGS (NREGS)
    ) u_rf (
        .clk     (clk),
        .rst_n   (rst_n),
        .ra_addr (rs1_idx),
        .ra_data (rf_a),
        .rb_addr (rs2_idx),
        .rb_data (rf_b),
        .we      (wb_en),
        .waddr   (wb_addr),
        .wdata   (wb_data)
    );

`ifdef DECODE_STAGE_BYPASS_EN
    assign byp_a  = wb_live && (wb_addr == rs1_idx);
    assign byp_b  = wb_live && (wb_addr == rs2_idx);
    assign opnd_a = byp_a ? wb_data : rf_a;
    assign opnd_b = byp_b ? wb_data : rf_b;
`else
    // Without forwarding a source under writeback waits one cycle for the array write.
    assign byp_a  = 1'b0;
    assign byp_b  = 1'b0;
    assign opnd_a = rf_a;
    assign opnd_b = rf_b;
`endif

    // Decode
    dec_op_t dec;

    always_comb begin
        dec         = '0;
        dec.funct3  = f3;
        dec.funct7  = f7_raw;
        dec.rs1     = opnd_a;
        dec.rs2     = opnd_b;
        dec.illegal = 1'b1;
        if (is_op) begin
            dec.illegal = !((f7_raw == F7_BASE) || (f7_raw == F7_MULDIV) ||
                            ((f7_raw == F7_ALT) && ((f3 == 3'd0) || (f3 == 3'd5))));
        end else if (is_opimm) begin
            dec.illegal = 1'b0;
            dec.funct7  = F7_BASE;
            dec.rs2     = sext12(in_instr[31:20]);
            if (is_shift) begin
                dec.rs2 = {{(XLEN-5){1'b0}}, in_instr[24:20]};
                if ((f7_raw == F7_ALT) && (f3 == 3'd5)) begin
                    dec.funct7 = F7_ALT;
                end else if (f7_raw != F7_BASE) begin
                    dec.illegal = 1'b1;
                end
            end
        end
        // Illegal ops carry rd=0 so they never claim or wait on a destination.
        if (!dec.illegal) begin
            dec.rd = rd_idx;
        end
    end

    // Scoreboard and hazard detection
    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;
    logic             rs1_hz;
    logic             rs2_hz;
    logic             rd_hz;
    logic             hazard;
    logic             accept;
    logic             out_valid_q;
    dec_op_t          out_q;

    assign rs1_hz = busy_q[rs1_idx] && !byp_a;
    assign rs2_hz = is_op && busy_q[rs2_idx] && !byp_b;
    // A destination retiring this cycle frees its slot for the new writer.
    assign rd_hz  = busy_q[dec.rd] && !(wb_live && (wb_addr == dec.rd));
    assign hazard = rs1_hz || rs2_hz || rd_hz;

    assign in_ready = (!out_valid_q || out_ready) && !hazard && !flush;
    assign accept   = in_valid && in_ready;

    always_comb begin
        busy_d = busy_q;
        if (wb_live) begin
            busy_d[wb_addr] = 1'b0;
        end
        if (flush && out_valid_q) begin
            busy_d[out_q.rd] = 1'b0;
        end
        // Set after clear: a new writer of the retiring register keeps it busy.
        if (accept && !dec.illegal) begin
            busy_d[dec.rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // Output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_q       <= '0;
        end else if (flush) begin
            out_valid_q <= 1'b0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            out_q       <= dec;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_funct3  = out_q.funct3;
    assign out_funct7  = out_q.funct7;
    assign out_rs1     = out_q.rs1;
    assign out_rs2     = out_q.rs2;
    assign out_rd      = out_q.rd;
    assign out_illegal = out_q.illegal;

endmodule
